// File: rtl/alu_sweep_pkg.sv
// Shared types and constants for the ALU self-test sweep controller.
package alu_sweep_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] MISR_POLY = 16'h100B;
  localparam logic [15:0] MISR_SEED = 16'hFFFF;
  localparam int          VEC_COUNT = 1024;
  localparam int          VEC_W     = 10;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(VEC_COUNT - 1);

  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [3:0] data);
    return {sig[14:0], 1'b0} ^ (sig[15] ? MISR_POLY : 16'h0000) ^ {12'h000, data};
  endfunction
endpackage

// File: rtl/alu_sweep_misr.sv
// 16-bit multiple-input signature register; load reseeds, enable folds in one 4-bit result.
module alu_sweep_misr
  import alu_sweep_pkg::*;
(
  input  logic        clk,
  input  logic        load,
  input  logic        enable,
  input  logic [3:0]  data,
  output logic [15:0] sig,
  output logic [15:0] sig_nxt
);

  assign sig_nxt = misr_step(sig, data);

  // Pure datapath state: always seeded by load before it is observed.
  always_ff @(posedge clk) begin
    if (load) begin
      sig <= MISR_SEED;
    end else if (enable) begin
      sig <= sig_nxt;
    end
  end

endmodule

// File: rtl/alu_sweep_ctrl.sv
// Exhaustive {op,A,B} sweep sequencer driving an external ALU and checking its MISR signature.
// Optional continuous mode (cont input, fail_count output) is built when ALU_SWEEP_CONT_EN is defined.
module alu_sweep_ctrl
  import alu_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
`ifdef ALU_SWEEP_CONT_EN
  input  logic        cont,
  output logic [7:0]  fail_count,
`endif
  input  logic [15:0] expected_sig,
  input  logic [3:0]  alu_result,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [1:0]  alu_op,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [VEC_W-1:0] idx, idx_nxt;
  logic [3:0]       settle, settle_nxt;
  logic             misr_load, misr_en, finish, clear;
  logic             last_settle;
  logic [15:0]      misr_sig, misr_nxt;

  assign last_settle = (settle == SETTLE_LAST);

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    settle_nxt = settle;
    misr_load  = 1'b0;
    misr_en    = 1'b0;
    finish     = 1'b0;
    clear      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt  = RUN;
          idx_nxt    = '0;
          settle_nxt = '0;
          misr_load  = 1'b1;
          clear      = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt  = IDLE;
          idx_nxt    = '0;
          settle_nxt = '0;
        end else if (last_settle) begin
          misr_en    = 1'b1;
          settle_nxt = '0;
          if (idx == VEC_LAST) begin
            state_nxt = DONE;
            idx_nxt   = '0;
            finish    = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end else begin
          settle_nxt = settle + 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
`ifdef ALU_SWEEP_CONT_EN
        if (cont) begin
          state_nxt = RUN;
          misr_load = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      settle <= '0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      settle <= settle_nxt;
    end
  end

  // Result registers: include the final sample, so they are valid in the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass      <= 1'b0;
      signature <= '0;
    end else if (clear) begin
      pass      <= 1'b0;
      signature <= '0;
    end else if (finish) begin
      pass      <= (misr_nxt == expected_sig);
      signature <= misr_nxt;
    end
  end

`ifdef ALU_SWEEP_CONT_EN
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_count <= '0;
    end else if (clear) begin
      fail_count <= '0;
    end else if (finish && (misr_nxt != expected_sig)) begin
      fail_count <= sat_inc8(fail_count);
    end
  end
`endif

  alu_sweep_misr u_misr (
    .clk     (clk),
    .load    (misr_load),
    .enable  (misr_en),
    .data    (alu_result),
    .sig     (misr_sig),
    .sig_nxt (misr_nxt)
  );

  assign {alu_op, alu_a, alu_b} = (state == RUN) ? idx : '0;
  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_sweep_ctrl.sv
// Scoreboard bench for alu_sweep_ctrl: S=1 and S=3 instances against a behavioural sweep model.
module tb_alu_sweep_ctrl;

  typedef struct packed {
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1, abort1, start3, abort3;
  logic [15:0] exp1, exp3;
  logic [3:0]  res1, res3;
  logic [3:0]  a1, b1, a3, b3;
  logic [1:0]  op1, op3;
  logic        busy1, done1, pass1, busy3, done3, pass3;
  logic [15:0] sig1, sig3;
`ifdef ALU_SWEEP_CONT_EN
  logic [7:0]  fc1, fc3;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q3[$];
  int   t1 = 0, t3 = 0, cur3 = 0;
  bit   act1 = 1'b0, act3 = 1'b0;
  bit   troj = 1'b0;
  logic [9:0] taddr = 10'h000;
  logic [15:0] golden;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_fn(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a & b;
      2'd2:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  // Signature of one full sweep, computed straight from the vector ordering and MISR rule.
  function automatic logic [15:0] ref_sig(input bit tj, input logic [9:0] ta);
    logic [15:0] s;
    logic [3:0]  r;
    logic [9:0]  v;
    s = 16'hFFFF;
    for (int k = 0; k < 1024; k++) begin
      v = 10'(k);
      r = alu_fn(v[9:8], v[7:4], v[3:0]);
      if (tj && v == ta) r[0] = 1'b1;
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {12'h000, r};
    end
    return s;
  endfunction

  assign res1 = alu_fn(op1, a1, b1) | ((troj && {op1, a1, b1} == taddr) ? 4'd1 : 4'd0);
  // Wrong value except in the last settle cycle, so an early sample corrupts the signature.
  assign res3 = ((cur3 % 3) == 2) ? alu_fn(op3, a3, b3) : ~alu_fn(op3, a3, b3);

  alu_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
`ifdef ALU_SWEEP_CONT_EN
    .cont(1'b0), .fail_count(fc1),
`endif
    .expected_sig(exp1), .alu_result(res1), .alu_a(a1), .alu_b(b1), .alu_op(op1),
    .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  alu_sweep_ctrl #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3),
`ifdef ALU_SWEEP_CONT_EN
    .cont(1'b0), .fail_count(fc3),
`endif
    .expected_sig(exp3), .alu_result(res3), .alu_a(a3), .alu_b(b3), .alu_op(op3),
    .busy(busy3), .done(done3), .pass(pass3), .signature(sig3)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors < 40) $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // Cycle monitor + scoreboard pop for the S=1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (act1) begin
        chk("busy1", 32'(busy1), 32'(t1 < 1024));
        chk("done1", 32'(done1), 32'(t1 == 1024));
        chk("vec1", 32'({op1, a1, b1}), (t1 < 1024) ? 32'(t1) : 32'd0);
        t1++;
        if (t1 > 1024) act1 = 1'b0;
      end else begin
        chk("idle_busy1", 32'(busy1), 32'd0);
        chk("idle_done1", 32'(done1), 32'd0);
        chk("idle_vec1", 32'({op1, a1, b1}), 32'd0);
      end
      if (done1) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done1: got done=1, expected no done");
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("signature1", 32'(sig1), 32'(e.sig));
          chk("pass1", 32'(pass1), 32'(e.pass));
        end
      end
    end
  end

  // Cycle monitor + scoreboard pop for the S=3 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      cur3 = t3;
      if (act3) begin
        chk("busy3", 32'(busy3), 32'(t3 < 3072));
        chk("done3", 32'(done3), 32'(t3 == 3072));
        chk("vec3", 32'({op3, a3, b3}), (t3 < 3072) ? 32'(t3 / 3) : 32'd0);
        t3++;
        if (t3 > 3072) act3 = 1'b0;
      end else begin
        chk("idle_busy3", 32'(busy3), 32'd0);
        chk("idle_done3", 32'(done3), 32'd0);
      end
      if (done3) begin
        if (q3.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done3: got done=1, expected no done");
        end else begin
          exp_t e;
          e = q3.pop_front();
          chk("signature3", 32'(sig3), 32'(e.sig));
          chk("pass3", 32'(pass3), 32'(e.pass));
        end
      end
    end
  end

  task automatic sweep1(input logic [15:0] es, input logic [15:0] msig);
    @(negedge clk);
    exp1   = es;
    start1 = 1'b1;
    q1.push_back('{sig: msig, pass: (es == msig)});
    @(posedge clk);
    #1 start1 = 1'b0;
    t1   = 0;
    act1 = 1'b1;
    @(negedge clk);
    chk("start_clr_pass1", 32'(pass1), 32'd0);
    chk("start_clr_sig1", 32'(sig1), 32'd0);
  endtask

  task automatic wait1();
    int i;
    i = 0;
    while (act1 && i < 1200) begin
      @(negedge clk);
      i++;
    end
    checks++;
    if (act1) begin
      errors++;
      $display("FAIL timeout1: sweep still active after %0d cycles", i);
      act1 = 1'b0;
    end
  endtask

  task automatic abort1_at(input int vec);
    repeat (vec) @(negedge clk);
    abort1 = 1'b1;
    @(posedge clk);
    #1 abort1 = 1'b0;
    act1 = 1'b0;
    void'(q1.pop_back());
    @(negedge clk);
    chk("abort_pass1", 32'(pass1), 32'd0);
    chk("abort_sig1", 32'(sig1), 32'd0);
    chk("abort_alu1", 32'({op1, a1, b1}), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [15:0] s, es;
    rst_n  = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    exp1   = 16'h0; exp3 = 16'h0;
    golden = ref_sig(1'b0, 10'h000);
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'({busy1, busy3}), 32'd0);
    chk("rst_done", 32'({done1, done3}), 32'd0);
    chk("rst_pass", 32'({pass1, pass3}), 32'd0);
    chk("rst_sig", 32'({sig1, sig3}), 32'd0);
    chk("rst_alu", 32'({op1, a1, b1, op3, a3, b3}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean ALU against the golden signature; a stray start mid-sweep must be ignored.
    sweep1(golden, golden);
    repeat (200) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    wait1();

    // Trojan stand-in at 10'h15A.
    troj = 1'b1; taddr = 10'h15A;
    s = ref_sig(1'b1, 10'h15A);
    sweep1(golden, s);
    wait1();
    chk("troj_sig_differs", 32'(sig1 != golden), 32'd1);
    troj = 1'b0;

    // Randomized sweeps: random trojan placement and golden/random expected value.
    for (int n = 0; n < 4; n++) begin
      troj  = 1'($urandom_range(0, 1));
      taddr = 10'($urandom_range(0, 1023));
      s     = ref_sig(troj, taddr);
      es    = ($urandom_range(0, 1) != 0) ? s : 16'($urandom);
      sweep1(es, s);
      wait1();
    end
    troj = 1'b0;

    // Abort at vector 500, then a normal sweep.
    sweep1(golden, golden);
    abort1_at(500);
    sweep1(golden, golden);
    wait1();

    // Abort at a random vector.
    sweep1(golden, golden);
    abort1_at($urandom_range(1, 1000));

    // Simultaneous start and abort in IDLE.
    @(negedge clk);
    start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0; abort1 = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", 32'(busy1), 32'd0);

    // S=3 sweep.
    @(negedge clk);
    exp3   = golden;
    start3 = 1'b1;
    q3.push_back('{sig: golden, pass: 1'b1});
    @(posedge clk);
    #1 start3 = 1'b0;
    t3   = 0;
    act3 = 1'b1;
    for (int i = 0; i < 3200 && act3; i++) @(negedge clk);
    checks++;
    if (act3) begin
      errors++;
      $display("FAIL timeout3: sweep still active");
      act3 = 1'b0;
    end

    // Asynchronous reset in the middle of a sweep.
    sweep1(golden, golden);
    repeat (300) @(negedge clk);
    #2 rst_n = 1'b0;
    act1 = 1'b0;
    void'(q1.pop_back());
    #1;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    chk("midrst_alu", 32'({op1, a1, b1}), 32'd0);
    chk("midrst_pass_sig", 32'({pass1, sig1}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
